// File: rtl/instr_mem_loader.sv
// Boot-time instruction loader: assembles bytes into LE words, writes imem.
// Optional CHECKSUM output enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          CNT_WIDTH = 9
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [CNT_WIDTH-1:0] NUM_WORDS,
  input  logic [7:0]           BYTE_IN,
  input  logic                 BYTE_VALID,
  output logic                 BYTE_READY,
  output logic                 MEM_WRITE,
  output logic [31:0]          MEM_ADDRESS,
  output logic [31:0]          MEM_WRITEDATA,
  input  logic                 MEM_BUSYWAIT,
  output logic                 CPU_HOLD,
  output logic                 DONE,
`ifdef INSTR_LOADER_CHECKSUM_EN
  output logic [31:0]          CHECKSUM,
`endif
  output logic                 ERROR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAXW =
    CNT_WIDTH'(MAX_WORDS);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0] idx_nxt;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [1:0]           bcnt_q;
  logic [31:0]          asm_q;
  logic                 err_q;

  logic idle_like;
  logic start_bad;
  logic start_zero;
  logic start_go;
  logic byte_fire;
  logic wr_done;
  logic last_word;

  assign idle_like  = (state_q == S_IDLE) ||
                      (state_q == S_DONE);
  assign start_bad  = idle_like && START &&
                      (NUM_WORDS > MAXW);
  assign start_zero = idle_like && START &&
                      (NUM_WORDS == '0);
  assign start_go   = idle_like && START &&
                      !(NUM_WORDS > MAXW) &&
                      (NUM_WORDS != '0);
  assign byte_fire  = (state_q == S_COLLECT) &&
                      BYTE_VALID;
  assign wr_done    = (state_q == S_WAIT) &&
                      !MEM_BUSYWAIT;
  assign idx_nxt    = idx_q + 1'b1;
  assign last_word  = (idx_nxt == cnt_q);

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_bad)       state_d = S_IDLE;
        else if (start_zero) state_d = S_DONE;
        else if (start_go)   state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (byte_fire && (bcnt_q == 2'd3))
          state_d = S_WRITE;
      end
      S_WRITE: state_d = S_WAIT;
      S_WAIT: begin
        if (!MEM_BUSYWAIT)
          state_d = last_word ? S_DONE : S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word index, byte assembly and error flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      bcnt_q <= '0;
      asm_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_bad) err_q <= 1'b1;
      if (start_zero || start_go) begin
        err_q  <= 1'b0;
        idx_q  <= '0;
        bcnt_q <= '0;
        cnt_q  <= NUM_WORDS;
      end
      if (byte_fire) begin
        asm_q[{bcnt_q, 3'b000} +: 8] <= BYTE_IN;
        bcnt_q <= bcnt_q + 2'd1;
      end
      if (wr_done) begin
        idx_q  <= idx_nxt;
        bcnt_q <= '0;
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running XOR of completed words for this load.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                      csum_q <= '0;
    else if (start_zero || start_go) csum_q <= '0;
    else if (wr_done)                csum_q <= csum_q ^ asm_q;
  end

  assign CHECKSUM = csum_q;
`endif

  // Address/data are gated so they read 0 outside a write.
  assign BYTE_READY    = (state_q == S_COLLECT);
  assign MEM_WRITE     = (state_q == S_WRITE) ||
                         (state_q == S_WAIT);
  assign MEM_ADDRESS   = MEM_WRITE ?
                         BASE_ADDR + (32'(idx_q) << 2) :
                         32'h0;
  assign MEM_WRITEDATA = MEM_WRITE ? asm_q : 32'h0;
  assign CPU_HOLD      = (state_q == S_COLLECT) ||
                         MEM_WRITE;
  assign DONE          = (state_q == S_DONE);
  assign ERROR         = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader against a byte-stream model.
// Define INSTR_LOADER_CHECKSUM_EN to also cover CHECKSUM.
module tb_instr_mem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  num_words;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_busywait;
  logic        cpu_hold;
  logic        done;
  logic        error;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instr_mem_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW),
    .CNT_WIDTH(9)
  ) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .START        (start),
    .NUM_WORDS    (num_words),
    .BYTE_IN      (byte_in),
    .BYTE_VALID   (byte_valid),
    .BYTE_READY   (byte_ready),
    .MEM_WRITE    (mem_write),
    .MEM_ADDRESS  (mem_address),
    .MEM_WRITEDATA(mem_writedata),
    .MEM_BUSYWAIT (mem_busywait),
    .CPU_HOLD     (cpu_hold),
    .DONE         (done),
`ifdef INSTR_LOADER_CHECKSUM_EN
    .CHECKSUM     (checksum),
`endif
    .ERROR        (error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  bq[$];
  logic [31:0] exp_words[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h",
                  tag, got, exp);
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_rdy"},  32'(byte_ready),   32'd0);
    check({tag, "_wr"},   32'(mem_write),    32'd0);
    check({tag, "_addr"}, mem_address,       32'd0);
    check({tag, "_data"}, mem_writedata,     32'd0);
    check({tag, "_hold"}, 32'(cpu_hold),     32'd0);
    check({tag, "_done"}, 32'(done),         32'd0);
    check({tag, "_err"},  32'(error),        32'd0);
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start     = 1'b1;
    num_words = 9'(n);
    @(negedge clk);
    start     = 1'b0;
    num_words = 9'($urandom);
  endtask

  // Runs one accepted load of n words from bq and checks it.
  task automatic run_load(input int n, input int lat,
                          input int gap, input bit poke,
                          input bit chk_lat);
    int          bi;
    int          wi;
    int          wcyc;
    int          it;
    int          last_fire;
    bit          prev_wr;
    bit          v;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [31:0] xs;
    exp_words.delete();
    xs = '0;
    for (int w = 0; w < n; w++) begin
      exp_words.push_back({bq[4*w+3], bq[4*w+2],
                           bq[4*w+1], bq[4*w]});
      xs ^= exp_words[w];
    end
    pulse_start(n);
    bi = 0; wi = 0; wcyc = 0; it = 0;
    last_fire = -100; prev_wr = 0;
    sa = '0; sd = '0;
    while (it < 20000) begin
      if (mem_write) begin
        if (!prev_wr) begin
          check("wr_addr", mem_address,
                BASE + 32'(4 * wi));
          if (wi < n)
            check("wr_data", mem_writedata,
                  exp_words[wi]);
          else
            check("extra_write", 32'd1, 32'd0);
          sa = mem_address;
          sd = mem_writedata;
          wi++;
        end else begin
          check("wr_addr_stable", mem_address, sa);
          check("wr_data_stable", mem_writedata, sd);
        end
        check("rdy_in_write", 32'(byte_ready), 32'd0);
      end
      prev_wr = mem_write;
      if (done) break;
      check("hold_busy", 32'(cpu_hold), 32'd1);
      if (mem_write) begin
        mem_busywait = (wcyc < lat);
        wcyc++;
      end else begin
        mem_busywait = 1'($urandom);
        wcyc = 0;
      end
      if (byte_ready) begin
        v = ($urandom_range(99) >= gap);
        if (bi >= bq.size()) v = 0;
        byte_valid = v;
        byte_in    = v ? bq[bi] : 8'($urandom);
        if (v) begin
          bi++;
          last_fire = it;
        end
      end else begin
        byte_valid = 1'($urandom);
        byte_in    = 8'($urandom);
      end
      start     = poke && (it == 5);
      num_words = '0;
      @(negedge clk);
      it++;
    end
    check("done_reached", 32'(done), 32'd1);
    check("n_writes", 32'(wi), 32'(n));
    check("n_bytes", 32'(bi), 32'(4 * n));
    check("hold_end", 32'(cpu_hold), 32'd0);
    check("err_end", 32'(error), 32'd0);
    if (chk_lat)
      check("done_latency", 32'(it - last_fire), 32'd3);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("checksum", checksum, xs);
`endif
    byte_valid   = 1'b0;
    mem_busywait = 1'b0;
    start        = 1'b0;
  endtask

  task automatic fill_random(input int nbytes);
    bq.delete();
    for (int i = 0; i < nbytes; i++)
      bq.push_back(8'($urandom));
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    num_words    = '0;
    byte_in      = '0;
    byte_valid   = 1'b0;
    mem_busywait = 1'b0;
    #12;
    check_idle_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    bq.delete();
    bq.push_back(8'h13); bq.push_back(8'h00);
    bq.push_back(8'h10); bq.push_back(8'h00);
    run_load(1, 0, 0, 0, 1);
    check("single_word", exp_words[0], 32'h0010_0013);

    fill_random(12);
    run_load(3, 3, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_random(4 * n);
      run_load(n, $urandom_range(0, 3),
               $urandom_range(0, 50), 1'(r % 2), 0);
    end

    pulse_start(257);
    check("bad_err", 32'(error), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_hold", 32'(cpu_hold), 32'd0);
    repeat (3) begin
      byte_valid = 1'b1;
      @(negedge clk);
      check("bad_nowrite", 32'(mem_write), 32'd0);
      check("bad_nordy", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;

    pulse_start(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_err", 32'(error), 32'd0);
    check("zero_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    check("zero_nowrite", 32'(mem_write), 32'd0);

    fill_random(4 * MAXW);
    run_load(MAXW, 0, 0, 0, 1);

    fill_random(4);
    pulse_start(1);
    byte_valid = 1'b1;
    byte_in    = 8'hEE;
    repeat (2) @(negedge clk);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_load(1, 1, 30, 0, 0);

    bq.delete();
    bq.push_back(8'h00); bq.push_back(8'h00);
    bq.push_back(8'hAA); bq.push_back(8'hAA);
    bq.push_back(8'h55); bq.push_back(8'h55);
    bq.push_back(8'h00); bq.push_back(8'h00);
    run_load(2, 1, 20, 0, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("checksum_directed", checksum,
          32'hAAAA_5555);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
